// File: rtl/eth_disp_pkg.sv
// Shared types for the Ethernet RX dispatcher.
//   NUM_CH      : number of downstream receive channels
//   ch_idx_t    : channel index; TAG_INVALID marks a byte whose frame is still undecided
//   state_e     : dispatcher FSM states
//   stage_t     : one delay-line slot {data, valid, last, dest, drop}
//   tag_ok()    : legal-and-enabled check for a channel tag byte
package eth_disp_pkg;

  localparam int unsigned NUM_CH = 3;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t TAG_INVALID = 2'd3;

  typedef enum logic [2:0] {
    WAIT_GAP,
    IDLE,
    HDR,
    FWD,
    DROP
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       last;
    ch_idx_t    dest;
    logic       drop;
  } stage_t;

  function automatic logic tag_ok(input logic [7:0] tag, input logic [NUM_CH-1:0] en);
    return (tag < 8'(NUM_CH)) && en[tag[1:0]];
  endfunction

endpackage

// File: rtl/eth_rx_delay_line.sv
// Fixed-depth shift register of stage_t slots.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   in_i              : slot entering stage 0 (already tagged by the caller)
//   retag_i           : resolve every undecided slot while it shifts
//   retag_drop_i      : resolve as dropped (else as retag_dest_i)
//   retag_dest_i      : destination channel for resolved slots
//   mark_last_i       : flag the youngest stored slot as last byte of its frame
//   tail_o            : oldest slot
module eth_rx_delay_line
  import eth_disp_pkg::*;
#(
  parameter int unsigned DEPTH = 15
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  stage_t  in_i,
  input  logic    retag_i,
  input  logic    retag_drop_i,
  input  ch_idx_t retag_dest_i,
  input  logic    mark_last_i,
  output stage_t  tail_o
);

  stage_t stage_q [DEPTH];
  stage_t stage_d [DEPTH];

  // Only slots still waiting on their frame's tag are touched; the tail of an
  // older, already-decided frame sharing the line keeps its own dest/drop.
  function automatic stage_t resolve(input stage_t s, input logic mark);
    stage_t r;
    r = s;
    if (retag_i && s.valid && !s.drop && (s.dest == TAG_INVALID)) begin
      if (retag_drop_i) r.drop = 1'b1;
      else              r.dest = retag_dest_i;
    end
    r.last = s.last | mark;
    return r;
  endfunction

  always_comb begin
    stage_d[0] = in_i;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      stage_d[k] = resolve(stage_q[k-1], (k == 1) && mark_last_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
    end
  end

  // With a single stage the marked byte is already leaving the line.
  always_comb begin
    tail_o = stage_q[DEPTH-1];
    if (DEPTH == 1) tail_o.last = tail_o.last | mark_last_i;
  end

endmodule

// File: rtl/eth_rx_dispatcher.sv
// Routes each complete MAC RX frame to one of three channels chosen by the
// tag byte at TAG_OFFSET; frames switch only on boundaries. Bytes wait in a
// TAG_OFFSET+1 deep delay line until the tag is known; latency TAG_OFFSET+2.
//   rgmii_clk, rst_n              : clock, asynchronous active-low reset
//   mac_rx_data/_valid            : incoming byte stream
//   chan_en[2:0]                  : channel enables, sampled at tag decision
//   ch{0,1,2}_data/_valid         : registered per-channel outputs
//   frm_cnt{0,1,2}, drop_cnt      : statistics (ETH_RX_DISP_STATS_EN), else 0
module eth_rx_dispatcher
  import eth_disp_pkg::*;
#(
  parameter int unsigned TAG_OFFSET = 14,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             rgmii_clk,
  input  logic             rst_n,
  input  logic [7:0]       mac_rx_data,
  input  logic             mac_rx_data_valid,
  input  logic [2:0]       chan_en,
  output logic [7:0]       ch0_data,
  output logic [7:0]       ch1_data,
  output logic [7:0]       ch2_data,
  output logic             ch0_valid,
  output logic             ch1_valid,
  output logic             ch2_valid,
  output logic [CNT_W-1:0] frm_cnt0,
  output logic [CNT_W-1:0] frm_cnt1,
  output logic [CNT_W-1:0] frm_cnt2,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned BC_W = $clog2(TAG_OFFSET + 2);
  typedef logic [BC_W-1:0] bcnt_t;
  localparam bcnt_t TAG_IDX = bcnt_t'(TAG_OFFSET);
  localparam bcnt_t BC_SAT  = bcnt_t'(TAG_OFFSET + 1);

  state_e  state_q, state_d;
  bcnt_t   cnt_q, cnt_d;
  ch_idx_t dest_q, dest_d;

  stage_t  in_s, tail;
  logic    at_tag, retag, retag_drop, mark_last, drop_evt;
  ch_idx_t retag_dest;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dest_d     = dest_q;
    at_tag     = 1'b0;
    retag      = 1'b0;
    retag_drop = 1'b0;
    retag_dest = dest_q;
    mark_last  = 1'b0;
    drop_evt   = 1'b0;
    in_s.data  = mac_rx_data;
    in_s.valid = mac_rx_data_valid;
    in_s.last  = 1'b0;
    in_s.dest  = TAG_INVALID;
    in_s.drop  = 1'b0;

    case (state_q)
      WAIT_GAP: begin
        in_s.drop = 1'b1;
        if (!mac_rx_data_valid) state_d = IDLE;
      end
      IDLE: begin
        if (mac_rx_data_valid) begin
          at_tag  = (TAG_OFFSET == 0);
          cnt_d   = bcnt_t'(1);
          state_d = HDR;
        end
      end
      HDR: begin
        if (mac_rx_data_valid) begin
          at_tag = (cnt_q == TAG_IDX);
          if (cnt_q != BC_SAT) cnt_d = cnt_q + bcnt_t'(1);
        end else begin
          // Runt: squash the partial frame still waiting in the line.
          retag      = 1'b1;
          retag_drop = 1'b1;
          drop_evt   = 1'b1;
          state_d    = IDLE;
        end
      end
      FWD: begin
        in_s.dest = dest_q;
        if (!mac_rx_data_valid) begin
          mark_last = 1'b1;
          state_d   = IDLE;
        end
      end
      DROP: begin
        in_s.drop = 1'b1;
        if (!mac_rx_data_valid) state_d = IDLE;
      end
      default: state_d = WAIT_GAP;
    endcase

    if (at_tag) begin
      retag = 1'b1;
      if (tag_ok(mac_rx_data, chan_en)) begin
        dest_d     = mac_rx_data[1:0];
        retag_dest = mac_rx_data[1:0];
        in_s.dest  = mac_rx_data[1:0];
        state_d    = FWD;
      end else begin
        retag_drop = 1'b1;
        in_s.drop  = 1'b1;
        drop_evt   = 1'b1;
        state_d    = DROP;
      end
    end
  end

  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_GAP;
      cnt_q   <= '0;
      dest_q  <= TAG_INVALID;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
    end
  end

  eth_rx_delay_line #(
    .DEPTH(TAG_OFFSET + 1)
  ) u_dly (
    .clk_i        (rgmii_clk),
    .rst_ni       (rst_n),
    .in_i         (in_s),
    .retag_i      (retag),
    .retag_drop_i (retag_drop),
    .retag_dest_i (retag_dest),
    .mark_last_i  (mark_last),
    .tail_o       (tail)
  );

  logic                fwd;
  logic [7:0]          data_q [NUM_CH];
  logic [NUM_CH-1:0]   valid_q;

  assign fwd = tail.valid && !tail.drop;

  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) data_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        valid_q[c] <= fwd && (tail.dest == ch_idx_t'(c));
        data_q[c]  <= (fwd && (tail.dest == ch_idx_t'(c))) ? tail.data : '0;
      end
    end
  end

  assign ch0_data  = data_q[0];
  assign ch1_data  = data_q[1];
  assign ch2_data  = data_q[2];
  assign ch0_valid = valid_q[0];
  assign ch1_valid = valid_q[1];
  assign ch2_valid = valid_q[2];

`ifdef ETH_RX_DISP_STATS_EN
  logic [CNT_W-1:0] frm_q [NUM_CH];
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) frm_q[c] <= '0;
    end else begin
      if (drop_evt && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (fwd && tail.last && (tail.dest == ch_idx_t'(c)) && (frm_q[c] != '1))
          frm_q[c] <= frm_q[c] + 1'b1;
      end
    end
  end

  assign frm_cnt0 = frm_q[0];
  assign frm_cnt1 = frm_q[1];
  assign frm_cnt2 = frm_q[2];
  assign drop_cnt = drop_q;
`else
  logic unused_stats;
  assign unused_stats = ^{tail.last, drop_evt};
  assign frm_cnt0 = '0;
  assign frm_cnt1 = '0;
  assign frm_cnt2 = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_rx_dispatcher.sv
// Directed bench for eth_rx_dispatcher. Each driven byte schedules its
// expected channel output 16 cycles later; a negedge monitor compares all
// channel outputs every cycle against that schedule.
module tb_eth_rx_dispatcher;
  import eth_disp_pkg::*;

  localparam int LAT  = 16;
  localparam int SLEN = 8192;
`ifdef ETH_RX_DISP_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [2:0]  chan_en = 3'b111;
  logic [7:0]  ch0_data, ch1_data, ch2_data;
  logic        ch0_valid, ch1_valid, ch2_valid;
  logic [15:0] frm_cnt0, frm_cnt1, frm_cnt2, drop_cnt;

  eth_rx_dispatcher #(.TAG_OFFSET(14), .CNT_W(16)) dut (
    .rgmii_clk         (clk),
    .rst_n             (rst_n),
    .mac_rx_data       (rx_data),
    .mac_rx_data_valid (rx_valid),
    .chan_en           (chan_en),
    .ch0_data          (ch0_data),
    .ch1_data          (ch1_data),
    .ch2_data          (ch2_data),
    .ch0_valid         (ch0_valid),
    .ch1_valid         (ch1_valid),
    .ch2_valid         (ch2_valid),
    .frm_cnt0          (frm_cnt0),
    .frm_cnt1          (frm_cnt1),
    .frm_cnt2          (frm_cnt2),
    .drop_cnt          (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {v2,v1,v0,d2,d1,d0}
  logic [26:0] sched [SLEN];
  int  n_checks = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;
  int  base = 8'h20;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en)
      check("chout", 32'({ch2_valid, ch1_valid, ch0_valid, ch2_data, ch1_data, ch0_data}),
            32'(sched[cyc]));
  end

  task automatic clear_sched(input int from);
    for (int i = from; i < SLEN; i++) sched[i] = '0;
  endtask

  task automatic expect_byte(input int dest, input logic [7:0] d);
    if (dest < 3) begin
      sched[cyc+LAT][24+dest]      = 1'b1;
      sched[cyc+LAT][dest*8 +: 8]  = d;
    end
  endtask

  task automatic check_cnts(input int f0, input int f1, input int f2, input int dr);
    check("frm_cnt0", 32'(frm_cnt0), 32'(STATS * f0));
    check("frm_cnt1", 32'(frm_cnt1), 32'(STATS * f1));
    check("frm_cnt2", 32'(frm_cnt2), 32'(STATS * f2));
    check("drop_cnt", 32'(drop_cnt), 32'(STATS * dr));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = '0;
    end
  endtask

  // dest 0..2 = expected channel, 3 = expected drop
  task automatic send_frame(input int len, input logic [7:0] tag, input int dest,
                            input int gap, input int toggle_at, input logic [2:0] en_after);
    logic [7:0] d;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      if (k == toggle_at) chan_en = en_after;
      d = (k == 14) ? tag : 8'(base + k);
      rx_data  = d;
      rx_valid = 1'b1;
      expect_byte(dest, d);
    end
    idle(gap);
    base = base + 37;
  endtask

  initial begin
    bit live;
    logic [7:0] d;
    clear_sched(0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'({ch2_valid, ch1_valid, ch0_valid, ch2_data, ch1_data, ch0_data}), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(WAIT_GAP));
    check_cnts(0, 0, 0, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(3);

    // 64-byte frame to ch1
    send_frame(64, 8'd1, 1, 20, -1, 3'b111);
    check_cnts(0, 1, 0, 0);

    // bad tag then tag 0, one-cycle gap
    send_frame(20, 8'd3, 3, 1, -1, 3'b111);
    send_frame(20, 8'd0, 0, 20, -1, 3'b111);
    check_cnts(1, 1, 0, 1);

    // disabled channel; enabling mid-frame does not rescue it
    chan_en = 3'b101;
    send_frame(30, 8'd1, 3, 20, 20, 3'b111);
    check_cnts(1, 1, 0, 2);

    // runt
    send_frame(10, 8'd2, 3, 20, -1, 3'b111);
    check("runt_state", 32'(dut.state_q), 32'(IDLE));
    check_cnts(1, 1, 0, 3);

    // valid held through reset release: that frame is ignored
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'(8'h80 + k);
      if (k == 5) begin
        #1 rst_n = 1'b0;
        clear_sched(cyc);
      end
      if (k == 8) check_cnts(0, 0, 0, 0);
      if (k == 10) #1 rst_n = 1'b1;
    end
    idle(1);
    send_frame(20, 8'd2, 2, 20, -1, 3'b111);
    check_cnts(0, 0, 1, 0);

    // reset mid-forward on ch2; tail of frame after release is ignored
    live = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      d = (k == 14) ? 8'd2 : 8'(8'h40 + k);
      rx_data  = d;
      rx_valid = 1'b1;
      if (live) expect_byte(2, d);
      if (k == 22) begin
        check("ch2_pre", 32'(ch2_valid), 32'd1);
        #2 rst_n = 1'b0;
        clear_sched(cyc);
        live = 1'b0;
        #1 check("ch2_rst", 32'({ch2_valid, ch2_data}), 32'd0);
      end
      if (k == 25) #1 rst_n = 1'b1;
    end
    idle(40);
    check_cnts(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
